// File: rtl/mul_share_pkg.sv
// Shared widths, pipeline depth and FSM encoding for the multiplier-sharing arbiter.
// sat_prod clamps the full product into the signed P_W-bit result range.
package mul_share_pkg;

    localparam int A_W      = 11;
    localparam int B_W      = 16;
    localparam int P_W      = 24;
    localparam int FULL_W   = 27;
    localparam int PIPE_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // The product fits in P_W signed bits only when the bits above the result sign all agree.
    function automatic logic [P_W-1:0] sat_prod(input logic signed [FULL_W-1:0] p);
        logic [FULL_W-P_W:0] hi;
        logic [P_W-1:0]      r;
        hi = p[FULL_W-1:P_W-1];
        if (hi == '0 || hi == '1) begin
            r = p[P_W-1:0];
        end else if (p[FULL_W-1]) begin
            r = {1'b1, {(P_W-1){1'b0}}};
        end else begin
            r = {1'b0, {(P_W-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_share_dsp_core.sv
// Signed A_W x B_W multiplier: input regs, product reg, output reg.
// Latency: 3 ce-qualified edges from operand capture to p_o; ce low freezes every stage.
// Backpressure: none; ce is the only stall.
module mul_share_dsp_core
    import mul_share_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ce_i,
    input  logic signed [A_W-1:0]    a_i,
    input  logic signed [B_W-1:0]    b_i,
    output logic signed [FULL_W-1:0] p_o
);

    logic signed [A_W-1:0]    a_q;
    logic signed [B_W-1:0]    b_q;
    logic signed [FULL_W-1:0] m_d, m_q, p_q;

    // Sign-extend both operands first so the product is computed at full width.
    assign m_d = FULL_W'(a_q) * FULL_W'(b_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
            m_q <= '0;
            p_q <= '0;
        end else if (ce_i) begin
            a_q <= a_i;
            b_q <= b_i;
            m_q <= m_d;
            p_q <= m_q;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one pipelined signed 11x16 multiplier; result 3 ce-qualified edges after accept.
// Backpressure: one-hot req_ready only in RUN with ce high; MUL_SHARE_SAT_EN saturates, else wraps to 24 bits.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 enable,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    output logic                 res_valid,
    output logic [ID_W-1:0]      res_id,
    output logic [P_W-1:0]       res_data,
    output logic                 busy,
    output logic                 drain_done
);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    state_e                   state_q, state_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    tag_t [PIPE_LAT-1:0]      tag_q;
    logic                     res_valid_q;
    logic [ID_W-1:0]          res_id_q;
    logic [P_W-1:0]           res_data_q, res_data_d;
    logic                     drain_done_q;

    logic [N_REQ-1:0]         gnt;
    logic [ID_W-1:0]          gnt_id;
    logic                     found;
    logic [A_W-1:0]           a_sel;
    logic [B_W-1:0]           b_sel;
    logic                     accept;
    logic                     in_flight;
    logic                     any_tag;
    logic signed [FULL_W-1:0] prod;

    // First pass covers requesters at or after the pointer, second pass wraps to the low ones.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
                found     = 1'b1;
                gnt[i]    = 1'b1;
                gnt_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found     = 1'b1;
                gnt[i]    = 1'b1;
                gnt_id    = ID_W'(i);
            end
        end
    end

    assign req_ready = ((state_q == ST_RUN) && ce) ? gnt : '0;
    assign accept    = |req_ready;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[i*A_W +: A_W];
                b_sel = req_b[i*B_W +: B_W];
            end
        end
    end

    // The last tag stage retires at the coming edge, so it does not hold DRAIN open.
    always_comb begin
        in_flight = 1'b0;
        any_tag   = 1'b0;
        for (int s = 0; s < PIPE_LAT; s++) begin
            any_tag = any_tag | tag_q[s].vld;
            if (s < PIPE_LAT-1) begin
                in_flight = in_flight | tag_q[s].vld;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (accept) begin
            ptr_d = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
        end
        case (state_q)
            ST_IDLE:  if (enable)     state_d = ST_RUN;
            ST_RUN:   if (!enable)    state_d = ST_DRAIN;
            ST_DRAIN: if (!in_flight) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    mul_share_dsp_core u_core (
        .clk_i (clk),
        .rst_i (reset),
        .ce_i  (ce),
        .a_i   (a_sel),
        .b_i   (b_sel),
        .p_o   (prod)
    );

`ifdef MUL_SHARE_SAT_EN
    assign res_data_d = sat_prod(prod);
`else
    assign res_data_d = P_W'(prod);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            tag_q        <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_data_q   <= '0;
            drain_done_q <= 1'b0;
        end else if (ce) begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            tag_q[0].vld <= accept;
            tag_q[0].id  <= gnt_id;
            for (int s = 1; s < PIPE_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            res_valid_q  <= tag_q[PIPE_LAT-1].vld;
            if (tag_q[PIPE_LAT-1].vld) begin
                res_id_q   <= tag_q[PIPE_LAT-1].id;
                res_data_q <= res_data_d;
            end
            drain_done_q <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
        end
    end

    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;
    assign res_data   = res_data_q;
    assign drain_done = drain_done_q;
    assign busy       = (state_q != ST_IDLE) || any_tag || res_valid_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboarded bench for mul_share_arbiter: accepts push expected results, result pulses pop and compare.
// Define MUL_SHARE_SAT_EN for both bench and RTL to check the saturating build.
module tb_mul_share_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 3;
    localparam int A_W   = 11;
    localparam int B_W   = 16;
    localparam int P_W   = 24;

`ifdef MUL_SHARE_SAT_EN
    localparam logic [P_W-1:0] EXP33 = 24'h800000;
`else
    localparam logic [P_W-1:0] EXP33 = 24'd1024;
`endif

    typedef struct {
        logic [ID_W-1:0] id;
        logic [P_W-1:0]  data;
        int              due;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ce;
    logic                 enable;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic                 res_valid;
    logic [ID_W-1:0]      res_id;
    logic [P_W-1:0]       res_data;
    logic                 busy;
    logic                 drain_done;

    int   a_v [N_REQ];
    int   b_v [N_REQ];
    exp_t sbq [$];
    int   grant_log [$];
    int   checks   = 0;
    int   failures = 0;
    int   raw_cycles = 0;
    int   ce_edges   = 0;

    mul_share_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_data   (res_data),
        .busy       (busy),
        .drain_done (drain_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        raw_cycles = raw_cycles + 1;
        if (ce) ce_edges = ce_edges + 1;
    end

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*A_W +: A_W] = A_W'(a_v[i]);
            req_b[i*B_W +: B_W] = B_W'(b_v[i]);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [P_W-1:0] model_prod(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
`ifdef MUL_SHARE_SAT_EN
        if (p > 64'sd8388607) p = 64'sd8388607;
        else if (p < -64'sd8388608) p = -64'sd8388608;
`endif
        return p[P_W-1:0];
    endfunction

    // Inputs change on the falling edge; sample the grant once they have settled.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!reset && ce && (req_ready != '0)) begin
            check_eq("ready_onehot", $countones(req_ready), 1);
            check_eq("ready_without_valid", 32'(req_ready & ~req_valid), 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i]) begin
                    e.id   = ID_W'(i);
                    e.data = model_prod(a_v[i], b_v[i]);
                    e.due  = ce_edges + 1 + 3;
                    sbq.push_back(e);
                    grant_log.push_back(i);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (res_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check_eq("res_unexpected", 32'(res_valid), 0);
            end else begin
                e = sbq.pop_front();
                check_eq("res_id", 32'(res_id), 32'(e.id));
                check_eq("res_data", 32'(res_data), 32'(e.data));
                check_eq("res_latency", ce_edges, e.due);
            end
        end
    end

    task automatic wait_res(input int max_cyc);
        int k = 0;
        while (res_valid !== 1'b1 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check_eq("wait_res_timeout", 32'(res_valid), 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        enable    = 1'b0;
        req_valid = '0;
        ce        = 1'b1;
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int acc_raw;
        int t0;
        int n;
        for (int i = 0; i < N_REQ; i++) begin
            a_v[i] = 0;
            b_v[i] = 0;
        end
        reset     = 1'b0;
        ce        = 1'b1;
        enable    = 1'b0;
        req_valid = '0;
        #1 reset = 1'b1;
        #1;
        check_eq("rst_res_valid", 32'(res_valid), 0);
        check_eq("rst_res_id", 32'(res_id), 0);
        check_eq("rst_res_data", 32'(res_data), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_drain_done", 32'(drain_done), 0);
        check_eq("rst_req_ready", 32'(req_ready), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle with enable low never grants.
        req_valid = '1;
        #1;
        check_eq("idle_req_ready", 32'(req_ready), 0);
        check_eq("idle_busy", 32'(busy), 0);
        @(negedge clk);
        req_valid = '0;

        // Single request: 3 * -5.
        enable = 1'b1;
        @(negedge clk);
        a_v[0] = 3;
        b_v[0] = -5;
        req_valid = 4'b0001;
        acc_raw = raw_cycles + 1;
        @(negedge clk);
        req_valid = '0;
        wait_res(10);
        check_eq("req032_latency", raw_cycles - acc_raw, 3);
        check_eq("req032_id", 32'(res_id), 0);
        check_eq("req032_data", 32'(res_data), 32'(24'hFFFFF1));

        // Overflowing product; pointer sits at 1 so requester 0 is reached by wrap-around.
        @(negedge clk);
        a_v[0] = -1024;
        b_v[0] = 32767;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        wait_res(10);
        check_eq("req033_data", 32'(res_data), 32'(EXP33));
        check_eq("req033_id", 32'(res_id), 0);

        // All requesters for 8 cycles from a fresh pointer.
        apply_reset();
        for (int i = 0; i < N_REQ; i++) begin
            a_v[i] = (i + 1) * 100 - 450;
            b_v[i] = 1000 * (i + 1) - 7;
        end
        enable = 1'b1;
        @(negedge clk);
        grant_log.delete();
        req_valid = '1;
        repeat (8) @(negedge clk);
        req_valid = '0;
        repeat (6) @(negedge clk);
        check_eq("rr_grant_count", grant_log.size(), 8);
        for (int k = 0; k < grant_log.size(); k++) check_eq("rr_grant", grant_log[k], k % 4);
        check_eq("rr_sb_drained", sbq.size(), 0);

        // ce low for 5 cycles with two operations in flight.
        grant_log.delete();
        a_v[0] = -77;  b_v[0] = 12345;
        a_v[1] = 1023; b_v[1] = -32768;
        req_valid = 4'b0011;
        t0 = raw_cycles;
        @(negedge clk);
        @(negedge clk);
        ce = 1'b0;
        req_valid = 4'b1100;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("ce_low_ready", 32'(req_ready), 0);
            check_eq("ce_low_res_valid", 32'(res_valid), 0);
            @(negedge clk);
        end
        ce = 1'b1;
        req_valid = '0;
        wait_res(20);
        check_eq("ce_stall_latency", raw_cycles - t0, 9);
        repeat (4) @(negedge clk);
        check_eq("ce_grant_count", grant_log.size(), 2);
        check_eq("ce_sb_drained", sbq.size(), 0);

        // Drop enable with 3 in flight; pointer is at 2 so grants wrap 2,3,0.
        grant_log.delete();
        req_valid = '1;
        repeat (3) @(negedge clk);
        req_valid = '0;
        enable = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (res_valid === 1'b1) n++;
            if (drain_done === 1'b1) break;
        end
        check_eq("drain_done_seen", 32'(drain_done), 1);
        check_eq("drain_results_at_done", n, 3);
        @(negedge clk);
        check_eq("busy_after_drain", 32'(busy), 0);
        check_eq("drain_done_pulse", 32'(drain_done), 0);
        check_eq("drain_grant_count", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            check_eq("drain_grant0", grant_log[0], 2);
            check_eq("drain_grant1", grant_log[1], 3);
            check_eq("drain_grant2", grant_log[2], 0);
        end

        // Reset with 2 in flight.
        enable = 1'b1;
        @(negedge clk);
        a_v[0] = 511; b_v[0] = 511;
        req_valid = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        enable = 1'b0;
        reset = 1'b1;
        sbq.delete();
        #1;
        check_eq("midrst_res_valid", 32'(res_valid), 0);
        check_eq("midrst_res_id", 32'(res_id), 0);
        check_eq("midrst_res_data", 32'(res_data), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_drain_done", 32'(drain_done), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (res_valid === 1'b1) n++;
        end
        check_eq("no_res_after_reset", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ID_W, default 3, requester index width (>= clog2(N_REQ)).
REQ-003 SHALL have port clk, input, 1, sole clock (rising edge).
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ce, input, 1, global clock enable; low freezes all state.
REQ-006 SHALL have port enable, input, 1, level request to run/accept operations.
REQ-007 SHALL have port req_valid, input, N_REQ, per-requester operand valid.
REQ-008 SHALL have port req_ready, output, N_REQ, one-hot grant/accept.
REQ-009 SHALL have port req_a, input, N_REQ*11, signed 11-bit operand per requester.
REQ-010 SHALL have port req_b, input, N_REQ*16, signed 16-bit operand per requester.
REQ-011 SHALL have port res_valid, output, 1, result valid pulse.
REQ-012 SHALL have port res_id, output, ID_W, requester index owning the result.
REQ-013 SHALL have port res_data, output, 24, signed product.
REQ-014 SHALL have port busy, output, 1, state != IDLE or operation in flight.
REQ-015 SHALL have port drain_done, output, 1, one-cycle pulse when drain completes.

Function
REQ-016 SHALL share one pipelined signed 11x16 multiplier among N_REQ requesters.
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN: IDLE->RUN when enable; RUN->DRAIN when !enable; DRAIN->IDLE when no operation in flight.
REQ-018 SHALL assert at most one req_ready bit, only in RUN with ce=1, granting the first valid requester at or after the round-robin pointer.
REQ-019 SHALL accept an operation on an edge with ce=1 and req_valid[i]&req_ready[i], then advance the pointer to (i+1) mod N_REQ; pointer unchanged otherwise.
REQ-020 SHALL accept one operation per ce-qualified cycle at full throughput.
REQ-021 SHALL assert res_valid for exactly one cycle, with res_id=i and res_data, 3 ce-qualified edges after the accepting edge.
REQ-022 SHALL carry requester index and valid through a 3-deep tag pipeline aligned with the datapath.
REQ-023 SHALL hold all registers, pointer, FSM and outputs unchanged while ce=0; req_ready SHALL be 0 while ce=0.
REQ-024 SHALL hold res_id/res_data at their last values when res_valid=0.
REQ-025 SHALL complete in-flight operations in DRAIN and accept no new ones; drain_done pulses on the DRAIN->IDLE edge.
REQ-026 SHALL, if enable returns high during DRAIN, finish draining to IDLE first, then re-enter RUN.

Reset
REQ-027 SHALL on reset: FSM=IDLE, pointer=0, tag pipeline cleared, req_ready=0, res_valid=0, res_id=0, res_data=0, busy=0, drain_done=0.
REQ-028 SHALL discard in-flight operations on reset mid-operation; no res_valid afterwards.

Configuration
REQ-029 SHALL honour macro MUL_SHARE_SAT_EN: defined -> 27-bit full product saturated to [-8388608, 8388607]; undefined -> low 24 bits kept (wrap).

Structure
REQ-030 SHALL place A_W=11, B_W=16, P_W=24, FULL_W=27, PIPE_LAT=3 and the FSM state enum in package mul_share_pkg.
REQ-031 SHALL instantiate one sub-module mul_share_dsp_core (input regs, product reg, ce-gated) for the multiplier; arbiter, tag pipeline, saturation stage and FSM stay in the top.

Verification
REQ-032 SHALL test: enable=1, req 0 only, a=3, b=-5 -> res_valid 3 cycles later, res_id=0, res_data=-15.
REQ-033 SHALL test: a=-1024, b=32767 -> res_data=1024 without MUL_SHARE_SAT_EN, -8388608 with it.
REQ-034 SHALL test: all 4 req_valid held high 8 cycles -> grants 0,1,2,3,0,1,2,3, results back-to-back in the same order.
REQ-035 SHALL test: ce low 5 cycles mid-stream -> no grants, no res_valid, results resume with latency extended by exactly 5.
REQ-036 SHALL test: enable dropped with 3 in flight -> 3 results, drain_done pulse on the 3rd, busy low the next cycle.
REQ-037 SHALL test: reset asserted with 2 in flight -> outputs zero immediately, no results after release.
